fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit.sv | 95 +++++++++
 tb/tb_fetch_pc_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC sequencer: it issues fetch requests, holds redirects that arrive
// while the pipeline cannot advance, and drops stale memory data after a flush.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic        rom_rdy,
    output logic [31:0] pc,
    output logic        inst_valid,
    output logic        fetch_stall_req,
    output logic        fetch_adel
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic        aligned;
    logic        advance;
    logic [31:0] next_pc;

    assign rom_addr = pc;

    // Outputs depend only on registered state/pc plus this cycle's handshake inputs.
    always_comb begin
        aligned         = (pc[1:0] == 2'b00);
        rom_en          = 1'b0;
        inst_valid      = 1'b0;
        fetch_stall_req = 1'b0;
        fetch_adel      = 1'b0;
        advance         = 1'b0;
        unique case (state)
            FETCH: begin
                rom_en          = aligned;
                fetch_stall_req = aligned & ~rom_rdy;
                advance         = ~stall & (rom_rdy | ~aligned);
                inst_valid      = advance & ~flush;
                fetch_adel      = advance & ~flush & ~aligned;
            end
            DISCARD: begin
                fetch_stall_req = 1'b1;
            end
            default: ;
        endcase

        if (pend_valid)
            next_pc = pend_addr;
        else if (branch_flag)
            next_pc = branch_addr;
        else
            next_pc = pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            // A redirect that cannot be consumed now is parked until the next advance.
            if (flush) begin
                pc         <= flush_pc;
                pend_valid <= 1'b0;
            end else if (advance) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end else if (branch_flag) begin
                pend_addr  <= branch_addr;
                pend_valid <= 1'b1;
            end

            unique case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (flush && rom_en && !rom_rdy) state <= DISCARD;
                DISCARD: if (rom_rdy) state <= FETCH;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_rdy;
    logic [31:0] pc;
    logic        inst_valid;
    logic        fetch_stall_req;
    logic        fetch_adel;

    int tests;
    int fails;

    // Model: running (left reset idle), waiting-for-stale-data, pc, parked redirect.
    bit          m_run;
    bit          m_disc;
    bit          m_pv;
    logic [31:0] m_pa;
    logic [31:0] m_pc;

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag     (branch_flag),
        .branch_addr     (branch_addr),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .rom_en          (rom_en),
        .rom_addr        (rom_addr),
        .rom_rdy         (rom_rdy),
        .pc              (pc),
        .inst_valid      (inst_valid),
        .fetch_stall_req (fetch_stall_req),
        .fetch_adel      (fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_disc = 1'b0;
        m_pv   = 1'b0;
        m_pa   = '0;
        m_pc   = RST_PC;
    endtask

    task automatic drv(input bit s, input bit b, input logic [31:0] ba,
                       input bit f, input logic [31:0] fp, input bit r);
        stall       = s;
        branch_flag = b;
        branch_addr = ba;
        flush       = f;
        flush_pc    = fp;
        rom_rdy     = r;
        #1;
    endtask

    // One clock: compare outputs mid-cycle, then step the model at the rising edge.
    task automatic cyc();
        bit e_en, e_req, e_iv, e_adel, go, mis, d0;
        @(negedge clk);
        mis    = (m_pc[1:0] != 2'b00);
        d0     = m_disc;
        e_en   = m_run && !m_disc && !mis;
        e_req  = m_disc || (e_en && !rom_rdy);
        go     = m_run && !m_disc && !stall && (rom_rdy || mis);
        e_iv   = go && !flush;
        e_adel = e_iv && mis;
        chk("rom_en", 32'(rom_en), 32'(e_en));
        chk("rom_addr", rom_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(e_iv));
        chk("fetch_stall_req", 32'(fetch_stall_req), 32'(e_req));
        chk("fetch_adel", 32'(fetch_adel), 32'(e_adel));
        @(posedge clk);
        if (d0 && rom_rdy) m_disc = 1'b0;
        if (flush) begin
            if (e_en && !rom_rdy) m_disc = 1'b1;
            m_pc = flush_pc;
            m_pv = 1'b0;
        end else if (go) begin
            m_pc = m_pv ? m_pa : (branch_flag ? branch_addr : m_pc + 32'd4);
            m_pv = 1'b0;
        end else if (branch_flag) begin
            m_pa = branch_addr;
            m_pv = 1'b1;
        end
        m_run = 1'b1;
        #1;
    endtask

    initial begin
        bit          s, b, f, r;
        logic [31:0] ba, fp;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, RST_PC);
        chk("reset_rom_en", 32'(rom_en), 32'd0);
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        chk("reset_stall_req", 32'(fetch_stall_req), 32'd0);
        chk("reset_adel", 32'(fetch_adel), 32'd0);

        // Reset release with memory always ready
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("ramp_pc", pc, 32'(i * 4));
            chk("ramp_rom_en", 32'(rom_en), 32'd1);
            chk("ramp_inst_valid", 32'(inst_valid), 32'd1);
            cyc();
        end
        chk("ramp_end_pc", pc, 32'h10);

        // Delayed branch taken on advance
        drv(0, 1, 32'h100, 0, 32'h0, 1);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        chk("branch_pc", pc, 32'h100);

        // Branch during stall is parked, then consumed
        drv(0, 0, 32'h0, 1, 32'h20, 1);
        cyc();
        chk("flush20_pc", pc, 32'h20);
        drv(1, 1, 32'h200, 0, 32'h0, 1);
        cyc();
        drv(1, 0, 32'h0, 0, 32'h0, 1);
        chk("stall_inst_valid", 32'(inst_valid), 32'd0);
        cyc();
        cyc();
        chk("stall_hold_pc", pc, 32'h20);
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        cyc();
        chk("pend_taken_pc", pc, 32'h200);
        cyc();
        chk("pend_cleared_pc", pc, 32'h204);

        // Memory wait states
        drv(0, 0, 32'h0, 1, 32'h40, 1);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 0);
        chk("wait_stall_req", 32'(fetch_stall_req), 32'd1);
        cyc();
        cyc();
        chk("wait_hold_pc", pc, 32'h40);
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        cyc();
        chk("wait_done_pc", pc, 32'h44);

        // Flush with request outstanding -> discard the stale return
        drv(0, 0, 32'h0, 1, 32'h180, 0);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 0);
        chk("discard_rom_en", 32'(rom_en), 32'd0);
        chk("discard_stall_req", 32'(fetch_stall_req), 32'd1);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        chk("discard_drop_iv", 32'(inst_valid), 32'd0);
        cyc();
        chk("refetch_rom_en", 32'(rom_en), 32'd1);
        chk("refetch_addr", rom_addr, 32'h180);

        // PC wraps modulo 2^32
        drv(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 1);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        cyc();
        chk("wrap_pc", pc, 32'h0);

        // Misaligned target raises the address error without a request
        drv(0, 1, 32'h102, 0, 32'h0, 1);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        chk("adel_rom_en", 32'(rom_en), 32'd0);
        chk("adel_flag", 32'(fetch_adel), 32'd1);
        chk("adel_inst_valid", 32'(inst_valid), 32'd1);
        cyc();

        // Asynchronous reset in the middle of an outstanding request
        drv(0, 0, 32'h0, 1, 32'h300, 1);
        cyc();
        drv(0, 0, 32'h0, 0, 32'h0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, RST_PC);
        chk("async_rst_rom_en", 32'(rom_en), 32'd0);
        chk("async_rst_stall_req", 32'(fetch_stall_req), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drv(0, 0, 32'h0, 0, 32'h0, 1);
        cyc();
        chk("post_rst_first_addr", rom_addr, RST_PC);
        chk("post_rst_first_en", 32'(rom_en), 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 3) == 0);
            ba = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 7) == 0) ba[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) ba = 32'hFFFF_FFFC;
            f  = ($urandom_range(0, 15) == 0);
            fp = $urandom & 32'h0000_0FFC;
            r  = ($urandom_range(0, 2) != 0);
            if (m_disc && f) r = 1'b0;
            drv(s, b, ba, f, fp, r);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
